stack_address_sequencer: RTL and testbench
==========================================

STACK_ADDRESS_SEQUENCER -- requirements
Module: stack_address_sequencer

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- ADDR_WIDTH, 14, memory word-address width.
- DATA_WIDTH, 32, data and register width.
- CODE_AREA_SIZE, 4096, first word address above the code area.
- STACK_SIZE, 2048, words per stack.
- NUM_STACKS, 2, number of independent stacks; stack k occupies [CODE_AREA_SIZE+k*STACK_SIZE, CODE_AREA_SIZE+(k+1)*STACK_SIZE-1].
- MAX_BURST, 16, maximum words per operation.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clock, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high.
- pc_enable, in, 1, advance or load the PC this cycle.
- pc_load, in, 1, load pc_target instead of incrementing.
- pc_target, in, DATA_WIDTH, branch target; low ADDR_WIDTH bits used.
- instruction_address, out, ADDR_WIDTH, current PC.
- input_address, in, DATA_WIDTH, ordinary load/store address.
- op_valid, in, 1, stack operation request.
- op_ready, out, 1, high in IDLE only.
- op_code, in, 2, 1=push, 2=pop; 0 and 3=no stack op.
- op_count, in, clog2(MAX_BURST)+1, words in the burst.
- stack_sel, in, max(1,clog2(NUM_STACKS)), target stack.
- mem_address, out, ADDR_WIDTH, data-memory address.
- mem_valid, out, 1, mem_address is a stack word this cycle.
- op_done, out, 1, one-cycle completion pulse.
- overflow, out, 1, one-cycle push-reject pulse.
- underflow, out, 1, one-cycle pop-reject pulse.
- stall, out, 1, sequencer busy; PC held.
- sp_out, out, DATA_WIDTH, zero-extended SP of stack_sel.

Function
REQ-003 SHALL keep one ADDR_WIDTH SP register per stack; the stack is full-descending; empty SP = stack base + STACK_SIZE.
REQ-004 SHALL implement FSM states IDLE, BURST and REJECT; op_ready = (state==IDLE).
REQ-005 In IDLE with op_valid=1 and op_code in {1,2}, SHALL latch op_code, stack_sel, count and SP at the edge; later input changes SHALL NOT affect the operation.
REQ-006 Push SHALL be accepted iff count <= words free (SP - base); pop SHALL be accepted iff count <= words used (empty SP - SP); otherwise SHALL go to REJECT.
REQ-007 REJECT SHALL last one cycle and assert op_done plus overflow (push) or underflow (pop); SP unchanged; mem_valid=0; then return to IDLE.
REQ-008 With count=0, SHALL go to REJECT without asserting an error flag, pulse op_done, and leave SP unchanged.
REQ-009 Accepted at edge t, BURST SHALL assert mem_valid on cycles t+1..t+count, one word per cycle.
- Push word i (i=1..count) address = SP0-i.
- Pop word i address = SP0+i-1.
REQ-010 SHALL write the final SP (SP0-count for push, SP0+count for pop) at the edge ending the last burst cycle; op_done SHALL assert on the last burst cycle; then return to IDLE.
REQ-011 When mem_valid=0, mem_address SHALL equal input_address[ADDR_WIDTH-1:0] combinationally.
REQ-012 stall SHALL equal (state != IDLE).
REQ-013 PC update on each edge when pc_enable=1 and stall=0:
- pc_load=1: PC <= pc_target[ADDR_WIDTH-1:0].
- otherwise: PC <= PC+1 modulo 2^ADDR_WIDTH (FFF..F wraps to 0).
REQ-014 When stall=1, SHALL hold PC regardless of pc_enable or pc_load.
REQ-015 In IDLE, op_valid with op_code 0 or 3 SHALL be ignored: no state change, no pulses.
REQ-016 op_valid while not IDLE SHALL be ignored, not queued.
REQ-017 sp_out SHALL reflect the registered SP (post-update value from the cycle after op_done).

Reset
REQ-018 At a rising edge with reset=1, SHALL apply:
- state=IDLE; PC=0; every SP=its empty value.
- mem_valid, op_done, overflow and underflow = 0 from that edge on.
REQ-019 Reset SHALL take priority over every other input.
REQ-020 Reset during BURST SHALL abort the operation; no final SP write survives.

Verification
REQ-021 Push: reset; push count=3, stack 0 at t -> mem_address 6143, 6142, 6141 with mem_valid on t+1..t+3; op_done at t+3; sp_out=6141 afterward.
REQ-022 Pop: then pop count=3, stack 0 -> addresses 6141, 6142, 6143; sp_out=6144; stack 1 SP stays 8192 throughout.
REQ-023 Pop reject: pop count=1 on empty stack 1 -> underflow and op_done at t+1; mem_valid=0; SP stays 8192.
REQ-024 Overflow: 128 pushes of 16 on stack 0 -> SP=4096; push 1 -> overflow pulse; SP stays 4096.
REQ-025 PC: pc_enable with load 100 -> 100, next cycle 101; during a 4-word burst with pc_enable=1, PC holds at 101 and stall=1; load 16383 then increment -> 0.
REQ-026 Reset mid-burst: reset at the second cycle of a 5-word push -> mem_valid=0 next cycle; sp0=6144; PC=0; op_ready=1.

Source files
------------

// File: rtl/stack_address_sequencer.sv
// stack_address_sequencer
//   Program counter plus a burst address generator for several full-descending
//   stacks placed directly above the code area. A push or pop of N words is
//   checked against the selected stack's occupancy. If it fits, the words are
//   issued one per cycle on mem_address/mem_valid. If it does not fit, or N is
//   zero, the request is rejected for one cycle. While an operation is in
//   flight the PC is frozen (stall).
//
// Ports
//   clock, reset          : single clock, synchronous active-high reset
//   pc_enable/pc_load     : advance (or load pc_target) the PC when not stalled
//   pc_target             : branch target, low ADDR_WIDTH bits used
//   instruction_address   : current PC
//   input_address         : ordinary load/store address, passed through when idle
//   op_valid/op_ready     : stack request handshake (ready only in IDLE)
//   op_code               : 1=push, 2=pop, others ignored
//   op_count, stack_sel   : burst length and target stack
//   mem_address/mem_valid : data-memory address, valid marks a stack word
//   op_done               : one-cycle completion pulse (accepted or rejected)
//   overflow/underflow    : one-cycle reject pulses for push/pop
//   stall                 : sequencer busy
//   sp_out                : zero-extended SP of stack_sel
module stack_address_sequencer #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int CODE_AREA_SIZE = 4096,
    parameter int STACK_SIZE     = 2048,
    parameter int NUM_STACKS     = 2,
    parameter int MAX_BURST      = 16,
    localparam int COUNT_W       = $clog2(MAX_BURST) + 1,
    localparam int SEL_W         = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pc_enable,
    input  logic                  pc_load,
    input  logic [DATA_WIDTH-1:0] pc_target,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    input  logic [DATA_WIDTH-1:0] input_address,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            op_code,
    input  logic [COUNT_W-1:0]    op_count,
    input  logic [SEL_W-1:0]      stack_sel,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_valid,
    output logic                  op_done,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] sp_out
);

    localparam int PAD_W = ADDR_WIDTH - COUNT_W;

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_REJECT} state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]                  pc_q, pc_d;
    logic [NUM_STACKS-1:0][ADDR_WIDTH-1:0]  sp_q, sp_d;
    logic [NUM_STACKS-1:0][ADDR_WIDTH-1:0]  base_addr, empty_addr;

    // Operation context captured at acceptance
    logic                  push_q, push_d;
    logic                  err_q, err_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [COUNT_W-1:0]    idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] sp0_q, sp0_d;

    logic [ADDR_WIDTH-1:0] sel_sp, sel_base, sel_empty;
    logic [ADDR_WIDTH-1:0] words_free, words_used, count_ext, count_q_ext, idx_ext;
    logic [ADDR_WIDTH-1:0] final_sp, burst_addr;
    logic                  is_push, is_stack_op, accept, fits, go_burst, last_word;

    logic unused_ok;
    assign unused_ok = &{1'b0, pc_target[DATA_WIDTH-1:ADDR_WIDTH],
                         input_address[DATA_WIDTH-1:ADDR_WIDTH]};

    // Fixed memory map of each stack
    for (genvar gi = 0; gi < NUM_STACKS; gi++) begin : g_stack_map
        assign base_addr[gi]  = ADDR_WIDTH'(CODE_AREA_SIZE + gi * STACK_SIZE);
        assign empty_addr[gi] = ADDR_WIDTH'(CODE_AREA_SIZE + (gi + 1) * STACK_SIZE);
    end

    // View of the stack addressed by the live stack_sel input
    always_comb begin
        sel_sp    = sp_q[0];
        sel_base  = base_addr[0];
        sel_empty = empty_addr[0];
        for (int k = 0; k < NUM_STACKS; k++) begin
            if (stack_sel == SEL_W'(k)) begin
                sel_sp    = sp_q[k];
                sel_base  = base_addr[k];
                sel_empty = empty_addr[k];
            end
        end
    end

    assign sp_out = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, sel_sp};

    // Acceptance decision
    assign is_push     = (op_code == 2'd1);
    assign is_stack_op = (op_code == 2'd1) || (op_code == 2'd2);
    assign accept      = (state_q == ST_IDLE) && op_valid && is_stack_op;
    assign words_free  = sel_sp - sel_base;
    assign words_used  = sel_empty - sel_sp;
    assign count_ext   = {{PAD_W{1'b0}}, op_count};
    assign fits        = is_push ? (count_ext <= words_free) : (count_ext <= words_used);
    assign go_burst    = accept && (op_count != '0) && fits;

    // Burst addressing relative to the latched SP
    assign count_q_ext = {{PAD_W{1'b0}}, count_q};
    assign idx_ext     = {{PAD_W{1'b0}}, idx_q};
    assign last_word   = (state_q == ST_BURST) && (idx_q == count_q - COUNT_W'(1));
    assign final_sp    = push_q ? (sp0_q - count_q_ext) : (sp0_q + count_q_ext);
    // Push word i (1-based) goes to SP0-i, pop word i to SP0+i-1; idx_q is i-1
    assign burst_addr  = push_q ? (sp0_q - idx_ext - ADDR_WIDTH'(1)) : (sp0_q + idx_ext);

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = go_burst ? ST_BURST : ST_REJECT;
            ST_BURST:  if (last_word) state_d = ST_IDLE;
            ST_REJECT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        op_ready  = (state_q == ST_IDLE);
        stall     = (state_q != ST_IDLE);
        mem_valid = (state_q == ST_BURST);
        op_done   = (state_q == ST_REJECT) || last_word;
        overflow  = (state_q == ST_REJECT) && err_q && push_q;
        underflow = (state_q == ST_REJECT) && err_q && !push_q;
        mem_address = mem_valid ? burst_addr : input_address[ADDR_WIDTH-1:0];
    end

    // Context capture and burst progress
    always_comb begin
        push_d  = push_q;
        err_d   = err_q;
        sel_d   = sel_q;
        count_d = count_q;
        sp0_d   = sp0_q;
        idx_d   = idx_q;
        if (accept) begin
            push_d  = is_push;
            // A zero-length request is rejected quietly, without an error flag
            err_d   = (op_count != '0);
            sel_d   = stack_sel;
            count_d = op_count;
            sp0_d   = sel_sp;
            idx_d   = '0;
        end else if (state_q == ST_BURST) begin
            idx_d = idx_q + COUNT_W'(1);
        end
    end

    // SP commit happens only on the edge closing the final burst word
    always_comb begin
        sp_d = sp_q;
        for (int k = 0; k < NUM_STACKS; k++) begin
            if (last_word && (sel_q == SEL_W'(k))) sp_d[k] = final_sp;
        end
    end

    // PC is frozen whenever the sequencer is busy
    always_comb begin
        pc_d = pc_q;
        if (pc_enable && !stall) begin
            pc_d = pc_load ? pc_target[ADDR_WIDTH-1:0] : pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= '0;
            sp_q    <= empty_addr;
            push_q  <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            count_q <= '0;
            sp0_q   <= '0;
            idx_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            push_q  <= push_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            count_q <= count_d;
            sp0_q   <= sp0_d;
            idx_q   <= idx_d;
        end
    end

    assign instruction_address = pc_q;

endmodule

// File: tb/tb_stack_address_sequencer.sv
module tb_stack_address_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        pc_enable;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [13:0] instruction_address;
    logic [31:0] input_address;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [4:0]  op_count;
    logic [0:0]  stack_sel;
    logic [13:0] mem_address;
    logic        mem_valid;
    logic        op_done;
    logic        overflow;
    logic        underflow;
    logic        stall;
    logic [31:0] sp_out;

    int vectors = 0;
    int miscompares = 0;

    stack_address_sequencer dut (
        .clock(clock), .reset(reset),
        .pc_enable(pc_enable), .pc_load(pc_load), .pc_target(pc_target),
        .instruction_address(instruction_address),
        .input_address(input_address),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_count(op_count), .stack_sel(stack_sel),
        .mem_address(mem_address), .mem_valid(mem_valid), .op_done(op_done),
        .overflow(overflow), .underflow(underflow), .stall(stall), .sp_out(sp_out)
    );

    always #5 clock = ~clock;

    // Present a request for exactly one rising edge (edge t); returns just after t
    task automatic issue(input logic [1:0] code, input int count, input int sel);
        @(negedge clock);
        op_valid  = 1'b1;
        op_code   = code;
        op_count  = 5'(count);
        stack_sel = 1'(sel);
        @(posedge clock);
        #1 op_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        input_address = 32'h0001_2345;
        stack_sel = 1'b0;
        @(negedge clock);
        vectors++; if (op_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b want=1", op_ready); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b want=0", stall); end
        vectors++; if ({mem_valid, op_done, overflow, underflow} !== 4'b0) begin miscompares++; $display("FAIL reset_pulses got=%b want=0000", {mem_valid, op_done, overflow, underflow}); end
        vectors++; if (instruction_address !== 14'd0) begin miscompares++; $display("FAIL reset_pc got=%0d want=0", instruction_address); end
        vectors++; if (sp_out !== 32'd6144) begin miscompares++; $display("FAIL reset_sp0 got=%0d want=6144", sp_out); end
        vectors++; if (mem_address !== 14'h2345) begin miscompares++; $display("FAIL reset_passthru got=%h want=2345", mem_address); end
        stack_sel = 1'b1; #1;
        vectors++; if (sp_out !== 32'd8192) begin miscompares++; $display("FAIL reset_sp1 got=%0d want=8192", sp_out); end
        stack_sel = 1'b0;
        $display("reset: state checked");
    endtask

    task automatic test_push;
        logic [13:0] exp_addr;
        issue(2'd1, 3, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            exp_addr = 14'(6144 - i);
            vectors++; if (mem_valid !== 1'b1 || mem_address !== exp_addr) begin miscompares++; $display("FAIL push_word%0d got=%b/%0d want=1/%0d", i, mem_valid, mem_address, exp_addr); end
            vectors++; if (op_done !== (i == 3)) begin miscompares++; $display("FAIL push_done%0d got=%b want=%b", i, op_done, (i == 3)); end
            vectors++; if (stall !== 1'b1 || op_ready !== 1'b0) begin miscompares++; $display("FAIL push_busy%0d got=%b%b want=10", i, stall, op_ready); end
            // Disturb latched inputs and post a request mid-burst
            if (i == 1) begin op_count = 5'd7; op_code = 2'd2; stack_sel = 1'b1; end
            if (i == 2) op_valid = 1'b1;
            if (i == 3) begin op_valid = 1'b0; stack_sel = 1'b0; end
        end
        @(negedge clock);
        vectors++; if (op_ready !== 1'b1 || mem_valid !== 1'b0 || op_done !== 1'b0) begin miscompares++; $display("FAIL push_end got=%b%b%b want=100", op_ready, mem_valid, op_done); end
        vectors++; if (sp_out !== 32'd6141) begin miscompares++; $display("FAIL push_sp got=%0d want=6141", sp_out); end
        @(negedge clock);
        vectors++; if (op_ready !== 1'b1 || mem_valid !== 1'b0) begin miscompares++; $display("FAIL push_noqueue got=%b%b want=10", op_ready, mem_valid); end
        stack_sel = 1'b1; #1;
        vectors++; if (sp_out !== 32'd8192) begin miscompares++; $display("FAIL push_sp1 got=%0d want=8192", sp_out); end
        stack_sel = 1'b0;
        $display("push stack=0 count=3 done");
    endtask

    task automatic test_pop;
        logic [13:0] exp_addr;
        issue(2'd2, 3, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            exp_addr = 14'(6140 + i);
            vectors++; if (mem_valid !== 1'b1 || mem_address !== exp_addr) begin miscompares++; $display("FAIL pop_word%0d got=%b/%0d want=1/%0d", i, mem_valid, mem_address, exp_addr); end
            vectors++; if (op_done !== (i == 3)) begin miscompares++; $display("FAIL pop_done%0d got=%b want=%b", i, op_done, (i == 3)); end
        end
        @(negedge clock);
        vectors++; if (sp_out !== 32'd6144) begin miscompares++; $display("FAIL pop_sp got=%0d want=6144", sp_out); end
        stack_sel = 1'b1; #1;
        vectors++; if (sp_out !== 32'd8192) begin miscompares++; $display("FAIL pop_sp1 got=%0d want=8192", sp_out); end
        stack_sel = 1'b0;
        $display("pop stack=0 count=3 done");
    endtask

    task automatic test_underflow;
        input_address = 32'h0000_0abc;
        issue(2'd2, 1, 1);
        @(negedge clock);
        vectors++; if ({op_done, underflow, overflow, mem_valid} !== 4'b1100) begin miscompares++; $display("FAIL uflow_pulse got=%b want=1100", {op_done, underflow, overflow, mem_valid}); end
        vectors++; if (mem_address !== 14'h0abc) begin miscompares++; $display("FAIL uflow_addr got=%h want=0abc", mem_address); end
        @(negedge clock);
        vectors++; if ({op_ready, op_done, underflow} !== 3'b100) begin miscompares++; $display("FAIL uflow_end got=%b want=100", {op_ready, op_done, underflow}); end
        vectors++; if (sp_out !== 32'd8192) begin miscompares++; $display("FAIL uflow_sp got=%0d want=8192", sp_out); end
        stack_sel = 1'b0;
        $display("pop stack=1 count=1 rejected");
    endtask

    task automatic test_zero_count;
        issue(2'd1, 0, 0);
        @(negedge clock);
        vectors++; if ({op_done, overflow, underflow, mem_valid} !== 4'b1000) begin miscompares++; $display("FAIL zero_pulse got=%b want=1000", {op_done, overflow, underflow, mem_valid}); end
        @(negedge clock);
        vectors++; if (op_ready !== 1'b1 || sp_out !== 32'd6144) begin miscompares++; $display("FAIL zero_end got=%b/%0d want=1/6144", op_ready, sp_out); end
        $display("push stack=0 count=0 rejected");
    endtask

    task automatic test_ignore_opcode;
        logic [1:0] codes [2];
        codes[0] = 2'd0; codes[1] = 2'd3;
        for (int j = 0; j < 2; j++) begin
            issue(codes[j], 4, 0);
            @(negedge clock);
            vectors++; if ({op_ready, op_done, mem_valid, overflow, underflow} !== 5'b10000) begin miscompares++; $display("FAIL ignore_code%0d got=%b want=10000", codes[j], {op_ready, op_done, mem_valid, overflow, underflow}); end
            $display("op_code=%0d ignored", codes[j]);
        end
    endtask

    task automatic test_pc;
        @(negedge clock);
        pc_enable = 1'b1; pc_load = 1'b1; pc_target = 32'd100;
        @(negedge clock);
        vectors++; if (instruction_address !== 14'd100) begin miscompares++; $display("FAIL pc_load got=%0d want=100", instruction_address); end
        pc_load = 1'b0;
        @(negedge clock);
        vectors++; if (instruction_address !== 14'd101) begin miscompares++; $display("FAIL pc_inc got=%0d want=101", instruction_address); end
        pc_enable = 1'b0;
        issue(2'd1, 4, 1);
        pc_enable = 1'b1; pc_load = 1'b1; pc_target = 32'd555;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            vectors++; if (stall !== 1'b1 || instruction_address !== 14'd101) begin miscompares++; $display("FAIL pc_hold%0d got=%b/%0d want=1/101", i, stall, instruction_address); end
        end
        @(negedge clock);
        vectors++; if (instruction_address !== 14'd101 || stall !== 1'b0) begin miscompares++; $display("FAIL pc_after got=%0d/%b want=101/0", instruction_address, stall); end
        stack_sel = 1'b1; #1;
        vectors++; if (sp_out !== 32'd8188) begin miscompares++; $display("FAIL pc_sp1 got=%0d want=8188", sp_out); end
        stack_sel = 1'b0;
        pc_target = 32'd16383;
        @(negedge clock);
        vectors++; if (instruction_address !== 14'd16383) begin miscompares++; $display("FAIL pc_max got=%0d want=16383", instruction_address); end
        pc_load = 1'b0;
        @(negedge clock);
        vectors++; if (instruction_address !== 14'd0) begin miscompares++; $display("FAIL pc_wrap got=%0d want=0", instruction_address); end
        pc_enable = 1'b0;
        $display("pc sequence load/inc/hold/wrap done");
    endtask

    task automatic test_overflow;
        for (int n = 1; n <= 128; n++) begin
            issue(2'd1, 16, 0);
            if (n < 128) begin
                repeat (16) @(posedge clock);
            end else begin
                for (int i = 1; i <= 16; i++) @(negedge clock);
                vectors++; if (mem_address !== 14'd4096 || op_done !== 1'b1) begin miscompares++; $display("FAIL fill_last got=%0d/%b want=4096/1", mem_address, op_done); end
            end
        end
        @(negedge clock);
        vectors++; if (sp_out !== 32'd4096) begin miscompares++; $display("FAIL fill_sp got=%0d want=4096", sp_out); end
        $display("push stack=0 128x16 filled");
        issue(2'd1, 1, 0);
        @(negedge clock);
        vectors++; if ({op_done, overflow, underflow, mem_valid} !== 4'b1100) begin miscompares++; $display("FAIL oflow_pulse got=%b want=1100", {op_done, overflow, underflow, mem_valid}); end
        @(negedge clock);
        vectors++; if (overflow !== 1'b0 || sp_out !== 32'd4096) begin miscompares++; $display("FAIL oflow_end got=%b/%0d want=0/4096", overflow, sp_out); end
        $display("push stack=0 count=1 rejected");
    endtask

    task automatic test_reset_mid_burst;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        pc_enable = 1'b1; pc_load = 1'b1; pc_target = 32'h77;
        @(negedge clock);
        pc_enable = 1'b0;
        issue(2'd1, 5, 0);
        @(negedge clock);
        vectors++; if (mem_valid !== 1'b1 || mem_address !== 14'd6143) begin miscompares++; $display("FAIL rmb_word1 got=%b/%0d want=1/6143", mem_valid, mem_address); end
        @(negedge clock);
        reset = 1'b1; pc_enable = 1'b1; pc_load = 1'b1; pc_target = 32'd55;
        op_valid = 1'b1; op_code = 2'd1; op_count = 5'd2;
        @(posedge clock);
        #1 reset = 1'b0; pc_enable = 1'b0; pc_load = 1'b0; op_valid = 1'b0;
        @(negedge clock);
        vectors++; if ({mem_valid, op_done, op_ready} !== 3'b001) begin miscompares++; $display("FAIL rmb_state got=%b want=001", {mem_valid, op_done, op_ready}); end
        vectors++; if (instruction_address !== 14'd0) begin miscompares++; $display("FAIL rmb_pc got=%0d want=0", instruction_address); end
        vectors++; if (sp_out !== 32'd6144) begin miscompares++; $display("FAIL rmb_sp got=%0d want=6144", sp_out); end
        repeat (5) @(negedge clock);
        vectors++; if (sp_out !== 32'd6144 || mem_valid !== 1'b0) begin miscompares++; $display("FAIL rmb_later got=%0d/%b want=6144/0", sp_out, mem_valid); end
        $display("reset during push stack=0 count=5 aborted");
    endtask

    initial begin
        reset = 1'b1; pc_enable = 1'b0; pc_load = 1'b0; pc_target = '0;
        input_address = '0; op_valid = 1'b0; op_code = '0; op_count = '0; stack_sel = '0;
        test_reset;
        test_push;
        test_pop;
        test_underflow;
        test_zero_count;
        test_ignore_opcode;
        test_pc;
        test_overflow;
        test_reset_mid_burst;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
